bit_scan_seq: RTL and testbench
===============================

Name: bit_scan_seq

Overview:
Multi-cycle, iterative bit-scan unit for the CPU execute stage. It handles the "find lowest/highest 1/0" operations. It accepts a 32-bit operand and a 2-bit scan type, then walks the operand STEP bits per cycle in scan order. It reports the bit index with a busy/done handshake, like the multiply/divide unit: the pipeline stalls on busy and captures the result on done.

Parameters:
WIDTH, 32, operand width in bits
STEP, 1, bits examined per cycle; power of two that divides WIDTH
RW, $clog2(WIDTH)+1, result width (6 at default)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  request a scan; sampled only in IDLE or DONE
cancel  in  1  abort (pipeline flush); synchronous, wins over start
data  in  WIDTH  operand, sampled with start
type  in  2  00 lowest 1, 01 lowest 0, 10 highest 1, 11 highest 0
busy  out  1  high while state==SCAN
done  out  1  one-cycle pulse; result valid from this cycle on
result  out  RW  bit index found, or WIDTH when no such bit exists

Behaviour:
- Reset (reset==0 at an edge): state IDLE; busy=0, done=0, result=0; internal operand/type/counter cleared.
- States: IDLE, SCAN, DONE. busy = (state==SCAN). done = (state==DONE). Both are registered decodes with no combinational path from the inputs.
- IDLE/DONE with start=1 and cancel=0:
  - latch data and type
  - cnt<=0
  - go to SCAN
  - result is not modified until completion.
- Target bit value: 1 for types 00 and 10, 0 for types 01 and 11.
- Scan position for bit k of the current step:
  - low types: pos = cnt*STEP + k
  - high types: pos = WIDTH-1 - (cnt*STEP + k)
- Within a step, the first match in scan order wins.
- SCAN, each cycle:
  - if any examined bit matches: result<=pos of the first match, go to DONE
  - else if cnt == WIDTH/STEP-1: result<=WIDTH, go to DONE
  - else cnt<=cnt+1.
- DONE: exactly one cycle. Next state is SCAN if start (back-to-back accepted), else IDLE.
- Latency (start sampled in cycle N, match at scan-order index i): done is high in cycle N+2+floor(i/STEP). All-miss at STEP=1: done in cycle N+33. The DONE cycle occurs with busy=0.
- Scan-order index i: low types i=pos; high types i=WIDTH-1-pos.
- start while SCAN: ignored, with no queuing. Data/type changes during SCAN have no effect (operand is latched).
- cancel=1 in any state: next state IDLE, no done pulse, result keeps its previous value. cancel+start in the same cycle: cancel wins.
- Reset mid-SCAN: immediate return to reset values; no done pulse.
- result holds its last value through IDLE until the next completion.
- Arithmetic: cnt is $clog2(WIDTH/STEP) bits wide and never wraps; terminal compare at WIDTH/STEP-1. The result zero-extends pos to RW bits.

Decomposition:
- Shared package (cpu_defs): type encodings (BS_LOW1=2'b00, BS_LOW0=2'b01, BS_HIGH1=2'b10, BS_HIGH0=2'b11) and state encodings (S_IDLE, S_SCAN, S_DONE).
- One sub-module, bit_scan_step: combinational. Inputs are the STEP-bit slice already reordered into scan order, plus the target value. Outputs are hit and first-hit offset.
- The parent owns the FSM, counter, slice selection and position arithmetic.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, result=0; no scan starts.
- Type 00, data=32'h0000_0100, start in cycle N → busy in N+1..N+9, done in N+10, result=8.
- Type 10, data=32'h0000_0001 → result=0, done in N+33. Type 11, data=32'hFFFF_FFFF → result=32 (not found), done in N+33.
- Type 01, data=32'h0000_0007 → result=3, done in N+5. Then assert start in the done cycle with type 11, data=32'h7FFF_FFFF → busy next cycle, result=31, done 2 cycles after that start.
- Type 00, data=32'h8000_0000, cancel in N+5 → IDLE in N+6, no done pulse, result unchanged. A start in N+3 during SCAN with different data is ignored.
- STEP=4 build: type 00, data=32'h0000_0030 → result=4, done in N+3. Type 10, data=0 → result=32, done in N+9.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the execute-stage bit-scan unit: scan types and FSM states.
package cpu_defs;

    typedef enum logic [1:0] {
        BS_LOW1  = 2'b00,
        BS_LOW0  = 2'b01,
        BS_HIGH1 = 2'b10,
        BS_HIGH0 = 2'b11
    } scan_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Types ending in 0 look for a 1, types ending in 1 look for a 0.
    function automatic logic scan_target(input logic [1:0] t);
        return ~t[0];
    endfunction

    function automatic logic scan_is_high(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/bit_scan_step.sv
// Combinational first-match finder over one STEP-bit slice already in scan order.
module bit_scan_step #(
    parameter int STEP = 1,
    parameter int OW   = (STEP > 1) ? $clog2(STEP) : 1
) (
    input  logic [STEP-1:0] i_slice,
    input  logic            i_target,
    output logic            o_hit,
    output logic [OW-1:0]   o_off
);

    // Walk from the back so the lowest matching offset is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_off = '0;
        for (int k = STEP - 1; k >= 0; k--) begin
            if (i_slice[k] == i_target) begin
                o_hit = 1'b1;
                o_off = OW'(k);
            end
        end
    end

endmodule

// File: rtl/bit_scan_seq.sv
// Iterative find-lowest/highest-1/0 unit with busy/done handshake for the execute stage.
module bit_scan_seq
    import cpu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int RW    = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_cancel,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_type,
    output logic             o_busy,
    output logic             o_done,
    output logic [RW-1:0]    o_result,
    output state_t           o_dbg_state
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int OW     = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEPS - 1);

    // Handshake: start is taken only in IDLE/DONE; cancel beats start in any state;
    // done is a one-cycle pulse and o_result is valid from that cycle until the next done.
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data,  w_data_nxt;
    logic [1:0]       r_type,  w_type_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [RW-1:0]    r_result, w_result_nxt;

    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_ordered;
    logic [RW-1:0]    w_base;
    logic [STEP-1:0]  w_slice;
    logic             w_hit;
    logic [OW-1:0]    w_off;
    logic [RW-1:0]    w_idx;
    logic [RW-1:0]    w_pos;

    // High scans run over the bit-reversed operand so both directions share one slicer.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = r_data[WIDTH-1-i];
        end
    end

    assign w_ordered = scan_is_high(r_type) ? w_rev : r_data;
    assign w_base    = RW'(r_cnt) * RW'(STEP);
    assign w_slice   = STEP'(w_ordered >> w_base);

    bit_scan_step #(
        .STEP (STEP),
        .OW   (OW)
    ) u_step (
        .i_slice  (w_slice),
        .i_target (scan_target(r_type)),
        .o_hit    (w_hit),
        .o_off    (w_off)
    );

    assign w_idx = w_base + RW'(w_off);
    assign w_pos = scan_is_high(r_type) ? (RW'(WIDTH - 1) - w_idx) : w_idx;

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_type_nxt   = r_type;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (i_start && !i_cancel) begin
                    w_state_nxt = S_SCAN;
                    w_data_nxt  = i_data;
                    w_type_nxt  = i_type;
                    w_cnt_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (i_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_result_nxt = w_pos;
                    w_state_nxt  = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_result_nxt = RW'(WIDTH);
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_type   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_type   <= w_type_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign o_busy      = (r_state == S_SCAN);
    assign o_done      = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bit_scan_seq.sv
// Scoreboard bench for bit_scan_seq: one STEP=1 and one STEP=4 instance against a bit-walking model.
module tb_bit_scan_seq;
    import cpu_defs::*;

    localparam int WIDTH = 32;
    localparam int RW    = 6;
    localparam int EW    = 1 + RW + 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cancel, sel;
    logic [31:0] data;
    logic [1:0]  typ;
    logic        start0, start1;
    logic        busy0, busy1, done0, done1;
    logic [RW-1:0] res0, res1;
    state_t      st0, st1;

    logic [1:0]    busy_v, done_v;
    logic [RW-1:0] res_v [2];
    state_t        st_v [2];

    assign start0   = start & ~sel;
    assign start1   = start & sel;
    assign busy_v   = {busy1, busy0};
    assign done_v   = {done1, done0};
    assign res_v[0] = res0;
    assign res_v[1] = res1;
    assign st_v[0]  = st0;
    assign st_v[1]  = st1;

    bit_scan_seq #(.WIDTH(WIDTH), .STEP(1), .RW(RW)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start0), .i_cancel(cancel),
        .i_data(data), .i_type(typ), .o_busy(busy0), .o_done(done0),
        .o_result(res0), .o_dbg_state(st0)
    );

    bit_scan_seq #(.WIDTH(WIDTH), .STEP(4), .RW(RW)) u_dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(start1), .i_cancel(cancel),
        .i_data(data), .i_type(typ), .o_busy(busy1), .o_done(done1),
        .o_result(res1), .o_dbg_state(st1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [RW-1:0] last_res [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (unit %0d, cyc %0d)", name, act, exp, sel, cyc);
        end
    endtask

    // Reference: walk bit positions in scan order, first bit equal to the target wins.
    function automatic void ref_scan(input logic [31:0] d, input logic [1:0] t, input int step,
                                     output logic [RW-1:0] res, output int lat);
        logic tgt;
        int   pos;
        tgt = (t == 2'b00 || t == 2'b10);
        res = RW'(WIDTH);
        lat = 2 + (WIDTH - 1) / step;
        for (int i = 0; i < WIDTH; i++) begin
            pos = (t >= 2'b10) ? (WIDTH - 1 - i) : i;
            if (d[pos] == tgt) begin
                res = RW'(pos);
                lat = 2 + i / step;
                break;
            end
        end
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard for that unit.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        for (int u = 0; u < 2; u++) begin
            if (done_v[u] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0][EW-1] != u[0]) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (unit %0d, cyc %0d)", u, cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (res_v[u] !== e[EW-2 -: RW]) begin
                        n_fail++;
                        $display("FAIL result: got %0d expected %0d (unit %0d, cyc %0d)", res_v[u], e[EW-2 -: RW], u, cyc);
                    end
                    n_cmp++;
                    if (cyc != int'(e[31:0])) begin
                        n_fail++;
                        $display("FAIL done_cycle: got %0d expected %0d (unit %0d)", cyc, e[31:0], u);
                    end
                    n_cmp++;
                    if (busy_v[u] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_in_done: got %0d expected 0 (unit %0d, cyc %0d)", busy_v[u], u, cyc);
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns one cycle later with the expected done cycle.
    task automatic issue(input logic [31:0] d, input logic [1:0] t, input logic [RW-1:0] res,
                         input int lat, input bit push, output int done_cyc);
        start = 1'b1;
        data  = d;
        typ   = t;
        done_cyc = cyc + lat;
        if (push) exp_q.push_back({sel, res, 32'(done_cyc)});
        @(negedge clk);
        start = 1'b0;
        data  = $urandom;
        typ   = 2'($urandom_range(0, 3));
    endtask

    task automatic watch(input int done_cyc);
        while (cyc < done_cyc) begin
            check("busy_during_scan", 32'(busy_v[sel]), 32'd1);
            check("result_held", 32'(res_v[sel]), 32'(last_res[sel]));
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input logic [RW-1:0] res);
        @(negedge clk);
        check("busy_after_done", 32'(busy_v[sel]), 32'd0);
        check("done_one_cycle", 32'(done_v[sel]), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        last_res[sel] = res;
    endtask

    task automatic run_op(input logic [31:0] d, input logic [1:0] t, input logic [RW-1:0] res, input int lat);
        int dc;
        issue(d, t, res, lat, 1'b1, dc);
        watch(dc);
        finish_op(res);
    endtask

    task automatic run_model(input logic [31:0] d, input logic [1:0] t);
        logic [RW-1:0] res;
        int lat;
        ref_scan(d, t, sel ? 4 : 1, res, lat);
        run_op(d, t, res, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished (cyc %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int dc, n0, c, lat;
        logic [RW-1:0] r;
        logic [31:0] d;
        logic [1:0] t;

        reset = 1'b0; start = 1'b1; cancel = 1'b0; sel = 1'b0; data = 32'h1; typ = 2'b00;
        last_res[0] = '0;
        last_res[1] = '0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_busy", 32'(busy_v[u]), 32'd0);
            check("reset_done", 32'(done_v[u]), 32'd0);
            check("reset_result", 32'(res_v[u]), 32'd0);
        end
        reset = 1'b1;
        start = 1'b0;
        idle(2);
        check("idle_after_reset", 32'(st_v[0]), 32'(S_IDLE));

        // Directed STEP=1 cases with hand-derived results and latencies.
        run_op(32'h0000_0100, 2'b00, 6'd8, 10);
        run_op(32'h0000_0001, 2'b10, 6'd0, 33);
        run_op(32'hFFFF_FFFF, 2'b11, 6'd32, 33);

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(32'h0000_0007, 2'b01, 6'd3, 5, 1'b1, dc);
        watch(dc);
        last_res[0] = 6'd3;
        issue(32'h7FFF_FFFF, 2'b11, 6'd31, 2, 1'b1, dc);
        watch(dc);
        finish_op(6'd31);

        // Cancel mid-scan; a start during SCAN with different data must be ignored.
        issue(32'h8000_0000, 2'b00, 6'd31, 33, 1'b0, dc);
        n0 = dc - 33;
        while (cyc < n0 + 3) @(negedge clk);
        start = 1'b1; data = 32'h0000_0001; typ = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 32'(busy_v[0]), 32'd0);
        check("cancel_state", 32'(st_v[0]), 32'(S_IDLE));
        check("cancel_result", 32'(res_v[0]), 32'(last_res[0]));
        idle(40);

        // Reset in the middle of a scan.
        issue(32'h0001_0000, 2'b00, 6'd16, 18, 1'b0, dc);
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_busy", 32'(busy_v[0]), 32'd0);
        check("midreset_result", 32'(res_v[0]), 32'd0);
        last_res[0] = '0;
        idle(25);

        // Directed STEP=4 cases.
        sel = 1'b1;
        run_op(32'h0000_0030, 2'b00, 6'd4, 3);
        run_op(32'h0000_0000, 2'b10, 6'd32, 9);

        // Randomized ops on both units, some cancelled at a random point.
        for (int n = 0; n < 80; n++) begin
            sel = 1'($urandom_range(0, 1));
            t = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: d = $urandom;
                1: d = 32'h1 << $urandom_range(0, 31);
                2: d = ~(32'h1 << $urandom_range(0, 31));
                3: d = 32'h0;
                default: d = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                ref_scan(d, t, sel ? 4 : 1, r, lat);
                c = $urandom_range(0, lat - 1);
                if (c == 0) begin
                    start = 1'b1; cancel = 1'b1; data = d; typ = t;
                    @(negedge clk);
                    start = 1'b0; cancel = 1'b0;
                end else begin
                    issue(d, t, r, lat, 1'b0, dc);
                    n0 = dc - lat;
                    while (cyc < n0 + c) @(negedge clk);
                    cancel = 1'b1;
                    @(negedge clk);
                    cancel = 1'b0;
                end
                check("rand_cancel_busy", 32'(busy_v[sel]), 32'd0);
                check("rand_cancel_result", 32'(res_v[sel]), 32'(last_res[sel]));
                idle(lat + 2);
            end else begin
                run_model(d, t);
            end
            idle($urandom_range(0, 3));
        end

        idle(5);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
